laser_score: RTL and testbench
==============================

LASER_SCORE -- requirements
Module: laser_score

Interface
REQ-001 SHALL have parameter NPTS, default 40: number of target points per frame.
REQ-002 SHALL have parameter R2, default 16: squared laser radius; a point is covered when its squared distance is <= R2.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1 bit: the X/Y point on this cycle is valid.
REQ-006 SHALL have ports X and Y, input, 4 bits each: point coordinates, streamed in the same order the laser stage receives them.
REQ-007 SHALL have port DONE, input, 1 bit: laser stage result-valid level.
REQ-008 SHALL have ports C1X, C1Y, C2X and C2Y, input, 4 bits each: the two circle centres from the laser stage.
REQ-009 SHALL have port SCORE_READY, input, 1 bit: downstream accepts SCORE.
REQ-010 SHALL have port SCORE, output, 6 bits: number of points covered by the union of the two circles.
REQ-011 SHALL have port SCORE_VALID, output, 1 bit: SCORE is valid.
REQ-012 SHALL have port BUSY, output, 1 bit: 1 in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD, WAIT_DONE, EVAL and HOLD.
REQ-014 In IDLE, IN_VALID=1 SHALL store the point at index 0, set the load counter to 1 and go to LOAD.
REQ-015 In LOAD, each IN_VALID=1 cycle SHALL store the point at the load counter index and increment the counter; cycles with IN_VALID=0 SHALL be stalls with no store.
REQ-016 Storing point index NPTS-1 SHALL move the block to WAIT_DONE on the next cycle.
REQ-017 IN_VALID SHALL be ignored in WAIT_DONE, EVAL and HOLD; points beyond NPTS are never stored.
REQ-018 DONE SHALL be ignored in IDLE and LOAD.
REQ-019 In WAIT_DONE, the first cycle sampled with DONE=1 SHALL latch C1X, C1Y, C2X and C2Y into internal registers, clear the accumulator and the eval index, and go to EVAL. DONE already high on entry SHALL be accepted on the first WAIT_DONE cycle.
REQ-020 EVAL SHALL process one point per cycle, eval index 0 to NPTS-1, using the latched centres only.
REQ-021 A point SHALL be covered when dx^2+dy^2 <= R2 for C1 or for C2, where dx and dy are absolute 4-bit differences and the sums are 9 bits with no overflow.
REQ-022 A point covered by both circles SHALL count once.
REQ-023 On eval index NPTS-1, SCORE SHALL be registered as accumulator plus that point's contribution, SCORE_VALID SHALL be set, and the state SHALL go to HOLD.
REQ-024 Latency: SCORE_VALID SHALL rise exactly NPTS+1 cycles after the cycle DONE was accepted (41 cycles for NPTS=40).
REQ-025 In HOLD, SCORE and SCORE_VALID SHALL stay stable until SCORE_READY=1 is sampled.
REQ-026 SCORE_READY=1 in HOLD SHALL clear SCORE_VALID and return to IDLE on that edge; SCORE SHALL keep its last value.
REQ-027 SCORE_READY SHALL have no effect outside HOLD.
REQ-028 IN_VALID=1 on the cycle HOLD exits SHALL NOT be stored; the next frame starts from IDLE.
REQ-029 SCORE range SHALL be 0 to NPTS; 6 bits SHALL be sufficient for NPTS <= 63.

Reset
REQ-030 RST=0 sampled on any edge SHALL force IDLE regardless of state, including mid-LOAD and mid-EVAL.
REQ-031 Reset SHALL clear SCORE to 0, SCORE_VALID to 0, the load counter, the eval index, the accumulator and the latched centres.
REQ-032 BUSY SHALL be 0 from the cycle after reset is sampled.
REQ-033 The point storage SHALL NOT need a reset; its contents SHALL never be observable before being rewritten.

Structure
REQ-034 The state enum and the constants NPTS_DEF=40 and R2_DEF=16 SHALL live in the shared package laser_pkg.
REQ-035 One sub-module SHALL exist: laser_cover_chk, purely combinational (point, two centres, R2 -> covered), instantiated once.

Verification
REQ-036 All 40 points at (8,8), no stalls, DONE with C1=(8,8), C2=(0,0) -> SCORE=40 and SCORE_VALID rises 41 cycles after DONE is accepted.
REQ-037 Points alternating (0,0) and (15,15), C1=(0,0), C2=(0,0) -> SCORE=20; coincident circles are not double counted.
REQ-038 Boundary: point (4,0) with C1=(0,0) is covered (16); point (4,1) with C1=(0,0) is not covered (17) -> exact count matches the reference model.
REQ-039 IN_VALID toggling 1/0 during load, DONE pulsed during LOAD, then DONE held high -> only the post-load DONE is used; SCORE matches the model; extra IN_VALID after 40 points is ignored.
REQ-040 SCORE_READY held low for 10 cycles in HOLD -> SCORE stable; SCORE_READY=1 -> SCORE_VALID=0 and BUSY=0 next cycle; a second frame scores correctly.
REQ-041 RST=0 asserted at eval index 20 -> IDLE, SCORE=0, SCORE_VALID=0 next cycle; a full new frame then scores correctly.

Source files
------------

// File: rtl/laser_pkg.sv
// laser_pkg: shared state, point type and distance helper
// for the laser coverage scorer.
package laser_pkg;

  localparam int NPTS_DEF = 40;
  localparam int R2_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    EVAL,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  // Squared distance: 15^2 + 15^2 = 450 fits 9 bits.
  function automatic logic [8:0] dist2(pt_t a, pt_t b);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] ex;
    logic [8:0] ey;
    dx = (a.x > b.x) ? a.x - b.x : b.x - a.x;
    dy = (a.y > b.y) ? a.y - b.y : b.y - a.y;
    ex = {5'd0, dx};
    ey = {5'd0, dy};
    return ex * ex + ey * ey;
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// laser_cover_chk: a point is covered when it lies inside
// either circle (union, so a double hit is still one bit).
module laser_cover_chk
  import laser_pkg::*;
(
  input  pt_t        pt,
  input  pt_t        c1,
  input  pt_t        c2,
  input  logic [8:0] r2,
  output logic       covered
);

  logic [8:0] d1;
  logic [8:0] d2;

  assign d1      = dist2(pt, c1);
  assign d2      = dist2(pt, c2);
  assign covered = (d1 <= r2) || (d2 <= r2);

endmodule

// File: rtl/laser_score.sv
// laser_score: buffers a frame of points, then counts how
// many fall inside the union of the two laser circles.
module laser_score
  import laser_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int R2   = R2_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       SCORE_READY,
  output logic [5:0] SCORE,
  output logic       SCORE_VALID,
  output logic       BUSY
);

  localparam int IW = $clog2(NPTS + 1);
  localparam logic [8:0] R2_W = 9'(R2);
  localparam logic [IW-1:0] LAST = IW'(NPTS - 1);
  localparam logic [IW-1:0] CNT = IW'(NPTS);

  state_t        state;
  logic [IW-1:0] ld_cnt;
  logic [IW-1:0] ev_idx;
  logic [IW-1:0] rd_idx;
  logic          ev_vld;
  logic [5:0]    acc;
  pt_t           c1;
  pt_t           c2;
  pt_t           pt_q;
  pt_t           mem [NPTS];

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          cov;
  logic [5:0]    acc_nx;

  assign BUSY   = (state != IDLE);
  assign wr_en  = IN_VALID &&
                  (state == IDLE || state == LOAD);
  assign wr_idx = (state == IDLE) ? '0 : ld_cnt;
  assign acc_nx = acc + {5'd0, cov};

  laser_cover_chk u_chk (
    .pt      (pt_q),
    .c1      (c1),
    .c2      (c2),
    .r2      (R2_W),
    .covered (cov)
  );

  // Storage is read through a register so it maps onto RAM;
  // EVAL spends its first cycle fetching point 0.
  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_idx] <= '{x: X, y: Y};
    if (state == EVAL && rd_idx < CNT)
      pt_q <= mem[rd_idx];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      ld_cnt      <= '0;
      ev_idx      <= '0;
      rd_idx      <= '0;
      ev_vld      <= 1'b0;
      acc         <= '0;
      c1          <= '0;
      c2          <= '0;
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            ld_cnt <= IW'(1);
            state  <= (NPTS == 1) ? WAIT_DONE : LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            ld_cnt <= ld_cnt + IW'(1);
            if (ld_cnt == LAST)
              state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (DONE) begin
            c1     <= '{x: C1X, y: C1Y};
            c2     <= '{x: C2X, y: C2Y};
            acc    <= '0;
            ev_idx <= '0;
            rd_idx <= '0;
            ev_vld <= 1'b0;
            state  <= EVAL;
          end
        end
        EVAL: begin
          ev_vld <= 1'b1;
          if (rd_idx < CNT)
            rd_idx <= rd_idx + IW'(1);
          if (ev_vld) begin
            acc    <= acc_nx;
            ev_idx <= ev_idx + IW'(1);
            if (ev_idx == LAST) begin
              SCORE       <= acc_nx;
              SCORE_VALID <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (SCORE_READY) begin
            SCORE_VALID <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_score.sv
// tb_laser_score: directed frames for the laser coverage
// scorer with hand-computed and model-derived scores.
module tb_laser_score;

  localparam int NPTS = 40;
  localparam int R2   = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic       DONE = 1'b0;
  logic [3:0] C1X = '0;
  logic [3:0] C1Y = '0;
  logic [3:0] C2X = '0;
  logic [3:0] C2Y = '0;
  logic       SCORE_READY = 1'b0;
  logic [5:0] SCORE;
  logic       SCORE_VALID;
  logic       BUSY;

  int tests = 0;
  int fails = 0;
  int px [NPTS];
  int py [NPTS];

  laser_score #(.NPTS(NPTS), .R2(R2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .X           (X),
    .Y           (Y),
    .DONE        (DONE),
    .C1X         (C1X),
    .C1Y         (C1Y),
    .C2X         (C2X),
    .C2Y         (C2Y),
    .SCORE_READY (SCORE_READY),
    .SCORE       (SCORE),
    .SCORE_VALID (SCORE_VALID),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, got, exp);
    end
  endtask

  function automatic int model(int c1x, int c1y,
                               int c2x, int c2y);
    int s;
    s = 0;
    for (int i = 0; i < NPTS; i++) begin
      int a, b, d1, d2;
      a  = px[i] - c1x;
      b  = py[i] - c1y;
      d1 = a * a + b * b;
      a  = px[i] - c2x;
      b  = py[i] - c2y;
      d2 = a * a + b * b;
      if (d1 <= R2 || d2 <= R2)
        s++;
    end
    return s;
  endfunction

  task automatic set_c(input int a, input int b,
                       input int c, input int d);
    C1X = 4'(a);
    C1Y = 4'(b);
    C2X = 4'(c);
    C2Y = 4'(d);
  endtask

  task automatic load_pts(input bit stall);
    for (int i = 0; i < NPTS; i++) begin
      IN_VALID = 1'b1;
      X = 4'(px[i]);
      Y = 4'(py[i]);
      tick();
      if (stall) begin
        IN_VALID = 1'b0;
        X = 4'($urandom_range(15));
        Y = 4'($urandom_range(15));
        tick();
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic do_frame(input string tag, input bit stall,
                          input int a, input int b,
                          input int c, input int d,
                          input int exp);
    int n;
    DONE = 1'b0;
    load_pts(stall);
    set_c(a, b, c, d);
    DONE = 1'b1;
    n = 0;
    while (!SCORE_VALID && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(SCORE_VALID), 1);
    check(tag, 32'(SCORE), 32'(exp));
    check({tag, "_model"}, 32'(SCORE),
          32'(model(a, b, c, d)));
    DONE = 1'b0;
    SCORE_READY = 1'b1;
    tick();
    SCORE_READY = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b0;
    tick();
    tick();
    check("rst_score", 32'(SCORE), 0);
    check("rst_valid", 32'(SCORE_VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    RST = 1'b1;

    // All points on C1; DONE high during load is ignored.
    for (int i = 0; i < NPTS; i++) begin
      px[i] = 8;
      py[i] = 8;
    end
    set_c(8, 8, 0, 0);
    DONE = 1'b1;
    load_pts(1'b0);
    check("f1_busy", 32'(BUSY), 1);
    check("f1_early", 32'(SCORE_VALID), 0);
    tick();
    for (int i = 0; i < NPTS; i++) tick();
    check("f1_lat40", 32'(SCORE_VALID), 0);
    tick();
    check("f1_lat41", 32'(SCORE_VALID), 1);
    check("f1_score", 32'(SCORE), 40);
    DONE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_score", 32'(SCORE), 40);
      check("hold_valid", 32'(SCORE_VALID), 1);
    end
    SCORE_READY = 1'b1;
    IN_VALID = 1'b1;
    X = 4'd1;
    Y = 4'd1;
    tick();
    SCORE_READY = 1'b0;
    IN_VALID = 1'b0;
    check("rel_valid", 32'(SCORE_VALID), 0);
    check("rel_busy", 32'(BUSY), 0);
    check("rel_score", 32'(SCORE), 40);

    // Coincident circles: half the points covered once.
    for (int i = 0; i < NPTS; i++) begin
      px[i] = (i % 2 == 0) ? 0 : 15;
      py[i] = px[i];
    end
    do_frame("coincident", 1'b0, 0, 0, 0, 0, 20);

    // Radius boundary: 16 in, 17 out, on both circles.
    for (int i = 0; i < NPTS; i++) begin
      if (i < 10) begin px[i] = 4; py[i] = 0; end
      else if (i < 20) begin px[i] = 4; py[i] = 1; end
      else if (i < 25) begin px[i] = 0; py[i] = 4; end
      else if (i < 35) begin px[i] = 3; py[i] = 3; end
      else if (i < 38) begin px[i] = 11; py[i] = 15; end
      else begin px[i] = 11; py[i] = 14; end
    end
    do_frame("boundary", 1'b1, 0, 0, 15, 15, 18);

    // Stalled load, decoy DONE pulse, extra IN_VALID.
    for (int i = 0; i < NPTS; i++) begin
      px[i] = (i * 7) % 16;
      py[i] = (i * 3 + 5) % 16;
    end
    set_c(0, 0, 0, 0);
    DONE = 1'b0;
    for (int i = 0; i < NPTS; i++) begin
      IN_VALID = 1'b1;
      X = 4'(px[i]);
      Y = 4'(py[i]);
      tick();
      IN_VALID = 1'b0;
      DONE = (i == 10);
      tick();
      DONE = 1'b0;
    end
    IN_VALID = 1'b1;
    X = 4'd0;
    Y = 4'd0;
    tick();
    tick();
    tick();
    check("wait_busy", 32'(BUSY), 1);
    check("wait_valid", 32'(SCORE_VALID), 0);
    set_c(5, 5, 12, 10);
    DONE = 1'b1;
    n = 0;
    while (!SCORE_VALID && n < 100) begin
      tick();
      n++;
    end
    IN_VALID = 1'b0;
    DONE = 1'b0;
    check("stall_valid", 32'(SCORE_VALID), 1);
    check("stall_model", 32'(SCORE),
          32'(model(5, 5, 12, 10)));
    SCORE_READY = 1'b1;
    tick();
    SCORE_READY = 1'b0;

    // Reset in the middle of evaluation.
    for (int i = 0; i < NPTS; i++) begin
      px[i] = 8;
      py[i] = 8;
    end
    set_c(8, 8, 0, 0);
    load_pts(1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    check("mid_busy", 32'(BUSY), 1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("mrst_busy", 32'(BUSY), 0);
    check("mrst_score", 32'(SCORE), 0);
    check("mrst_valid", 32'(SCORE_VALID), 0);
    tick();
    check("mrst_stay", 32'(SCORE_VALID), 0);

    for (int i = 0; i < NPTS; i++) begin
      px[i] = (i % 2 == 0) ? 0 : 15;
      py[i] = px[i];
    end
    do_frame("after_rst", 1'b0, 15, 15, 0, 0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
